// File: rtl/clock_pkg.sv
// Shared constants and BCD segment decode
// for the clock display path.
package clock_pkg;

  localparam logic [2:0] IDX_S0 = 3'd0;
  localparam logic [2:0] IDX_S1 = 3'd1;
  localparam logic [2:0] IDX_M0 = 3'd2;
  localparam logic [2:0] IDX_M1 = 3'd3;
  localparam logic [2:0] IDX_H0 = 3'd4;
  localparam logic [2:0] IDX_H1 = 3'd5;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
    logic       alarm;
  } snap_t;

  function automatic logic [6:0] bcd_to_seg(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/clock_display_scan_if.sv
// Time digits in, scanned display out,
// between the clock core and the scan driver.
interface clock_display_scan_if;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [3:0] M_in1;
  logic [3:0] M_in0;
  logic [3:0] S_in1;
  logic [3:0] S_in0;
  logic       Alarm;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  modport master (
    output H_in1, H_in0, M_in1, M_in0,
    output S_in1, S_in0, Alarm,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  H_in1, H_in0, M_in1, M_in0,
    input  S_in1, S_in0, Alarm,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/seg7_decode.sv
// BCD digit to active-high segments,
// dash for values above nine.
module seg7_decode
  import clock_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  assign seg = bcd_to_seg(bcd);
endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed display driver with
// per-frame snapshot, separator and alarm blink.
module clock_display_scan
  import clock_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter int BLINK_FRAMES   = 32,
  parameter int ACTIVE_LOW_OUT = 1,
  parameter int LZ_BLANK       = 1
) (
  input  logic clk,
  input  logic reset,
  clock_display_scan_if.slave bus
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [PW-1:0] PRE_TC = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLK_TC = BW'(BLINK_FRAMES - 1);
  localparam logic OFF = (ACTIVE_LOW_OUT != 0);

  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_off_q, blink_off_d;
  snap_t         snap_q, snap_d, snap_in;
  logic          frame_done_q, frame_done_d;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          tc, wrap, blank;
  logic [3:0]    digit;
  logic [6:0]    dec_seg;

  assign snap_in = {bus.H_in1, bus.H_in0,
                    bus.M_in1, bus.M_in0,
                    bus.S_in1, bus.S_in0,
                    bus.Alarm};

  assign tc   = (pre_cnt_q == PRE_TC);
  assign wrap = tc && (idx_q == IDX_H1);

  // Scan position, frame snapshot and blink phase
  always_comb begin
    pre_cnt_d    = tc ? '0 : pre_cnt_q + 1'b1;
    idx_d        = idx_q;
    snap_d       = snap_q;
    frame_done_d = wrap;
    blink_cnt_d  = blink_cnt_q;
    blink_off_d  = blink_off_q;
    if (tc) begin
      idx_d = wrap ? IDX_S0 : idx_q + 3'd1;
    end
    if (wrap) begin
      snap_d = snap_in;
      if (!snap_q.alarm) begin
        blink_cnt_d = '0;
        blink_off_d = 1'b0;
      end else if (blink_cnt_q == BLK_TC) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Select the digit currently being scanned
  always_comb begin
    digit = '0;
    unique case (1'b1)
      idx_q == IDX_S0: digit = snap_q.s0;
      idx_q == IDX_S1: digit = snap_q.s1;
      idx_q == IDX_M0: digit = snap_q.m0;
      idx_q == IDX_M1: digit = snap_q.m1;
      idx_q == IDX_H0: digit = snap_q.h0;
      idx_q == IDX_H1: digit = {2'b00, snap_q.h1};
      default:         digit = '0;
    endcase
  end

  seg7_decode u_dec (
    .bcd (digit),
    .seg (dec_seg)
  );

  assign blank = (snap_q.alarm && blink_off_q)
              || ((LZ_BLANK != 0)
                  && (idx_q == IDX_H1)
                  && (snap_q.h1 == 2'd0));

  // Next output levels, blanked then polarity-adjusted
  always_comb begin
    an_d  = 6'b000001 << idx_q;
    seg_d = dec_seg;
    dp_d  = ((idx_q == IDX_M0) || (idx_q == IDX_H0))
         && !snap_q.s0[0];
    if (blank) begin
      an_d  = '0;
      seg_d = SEG_OFF;
      dp_d  = 1'b0;
    end
    if (OFF) begin
      an_d  = ~an_d;
      seg_d = ~seg_d;
      dp_d  = ~dp_d;
    end
  end

  // State and output registers, snapshot follows inputs in reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_cnt_q    <= '0;
      idx_q        <= IDX_S0;
      blink_cnt_q  <= '0;
      blink_off_q  <= 1'b0;
      snap_q       <= snap_in;
      frame_done_q <= 1'b0;
      an_q         <= {6{OFF}};
      seg_q        <= {7{OFF}};
      dp_q         <= OFF;
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_off_q  <= blink_off_d;
      snap_q       <= snap_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Random-stimulus bench for clock_display_scan,
// two parameter sets against a frame-level model.
module tb_clock_display_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cur [6];
  logic       alm;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  clock_display_scan_if bus0 ();
  clock_display_scan_if bus1 ();

  assign bus0.S_in0 = cur[0];
  assign bus0.S_in1 = cur[1];
  assign bus0.M_in0 = cur[2];
  assign bus0.M_in1 = cur[3];
  assign bus0.H_in0 = cur[4];
  assign bus0.H_in1 = cur[5][1:0];
  assign bus0.Alarm = alm;
  assign bus1.S_in0 = cur[0];
  assign bus1.S_in1 = cur[1];
  assign bus1.M_in0 = cur[2];
  assign bus1.M_in1 = cur[3];
  assign bus1.H_in0 = cur[4];
  assign bus1.H_in1 = cur[5][1:0];
  assign bus1.Alarm = alm;

  clock_display_scan #(
    .SCAN_DIV(4), .BLINK_FRAMES(2),
    .ACTIVE_LOW_OUT(1), .LZ_BLANK(1)
  ) u_dut0 (
    .clk(clk), .reset(rst_n), .bus(bus0)
  );

  clock_display_scan #(
    .SCAN_DIV(3), .BLINK_FRAMES(3),
    .ACTIVE_LOW_OUT(0), .LZ_BLANK(0)
  ) u_dut1 (
    .clk(clk), .reset(rst_n), .bus(bus1)
  );

  int sd  [2] = '{4, 3};
  int bf  [2] = '{2, 3};
  int alo [2] = '{1, 0};
  int lz  [2] = '{1, 0};

  logic [6:0] segtab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
    7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  int e    [2];
  int sdig [2][6];
  int salm [2];
  int bcnt [2];
  int boff [2];

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h",
               tag, $time, got, exp);
    end
  endtask

  // Frame-level reference: cycle count since reset gives
  // the digit shown; snapshot and blink advance per frame.
  task automatic model_step(
    input  int k,
    output logic [5:0] ean,
    output logic [6:0] eseg,
    output logic       edp,
    output logic       efd
  );
    int flen, pos, d;
    bit lit;
    flen = 6 * sd[k];
    ean = '0; eseg = '0; edp = 1'b0; efd = 1'b0;
    if (!rst_n) begin
      e[k] = 0;
      for (int i = 0; i < 6; i++) sdig[k][i] = int'(cur[i]);
      sdig[k][5] = sdig[k][5] % 4;
      salm[k] = int'(alm);
      bcnt[k] = 0;
      boff[k] = 0;
    end else begin
      pos = e[k] % flen;
      d   = pos / sd[k];
      lit = !(salm[k] != 0 && boff[k] != 0)
         && !(lz[k] != 0 && d == 5 && sdig[k][5] == 0);
      if (lit) begin
        ean  = 6'(1 << d);
        eseg = segtab[sdig[k][d]];
        edp  = (d == 2 || d == 4) && (sdig[k][0] % 2 == 0);
      end
      efd = (pos == flen - 1);
      if (pos == flen - 1) begin
        if (salm[k] == 0) begin
          bcnt[k] = 0;
          boff[k] = 0;
        end else begin
          bcnt[k]++;
          if (bcnt[k] == bf[k]) begin
            bcnt[k] = 0;
            boff[k] = 1 - boff[k];
          end
        end
        for (int i = 0; i < 6; i++) sdig[k][i] = int'(cur[i]);
        sdig[k][5] = sdig[k][5] % 4;
        salm[k] = int'(alm);
      end
      e[k]++;
    end
    if (alo[k] != 0) begin
      ean  = ~ean;
      eseg = ~eseg;
      edp  = ~edp;
    end
  endtask

  logic [5:0] x_an;
  logic [6:0] x_seg;
  logic       x_dp, x_fd;
  int         dsel;

  initial begin
    rst_n  = 1'b0;
    alm    = 1'b0;
    cur[0] = 4'd6; cur[1] = 4'd5;
    cur[2] = 4'd4; cur[3] = 4'd3;
    cur[4] = 4'd2; cur[5] = 4'd1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c < 3) rst_n = 1'b0;
      else if (c < 400) rst_n = 1'b1;
      if (c == 15) cur[0] = 4'd7;
      if (c == 60) alm = 1'b1;
      if (c == 300) alm = 1'b0;
      if (c == 340) begin
        cur[5] = 4'd0;
        cur[4] = 4'd7;
        cur[2] = 4'd12;
      end
      if (c == 400) rst_n = 1'b0;
      if (c == 401) rst_n = 1'b1;
      if (c >= 420) begin
        rst_n = ($urandom_range(0, 399) != 0);
        if ($urandom_range(0, 199) == 0) alm = ~alm;
        if ($urandom_range(0, 7) == 0) begin
          dsel = int'($urandom_range(0, 5));
          if (dsel == 5)
            cur[5] = 4'($urandom_range(0, 3));
          else
            cur[dsel] = 4'($urandom_range(0, 15));
        end
      end
      @(posedge clk);
      #1;
      model_step(0, x_an, x_seg, x_dp, x_fd);
      check("an0", 32'(bus0.an), 32'(x_an));
      check("seg0", 32'(bus0.seg), 32'(x_seg));
      check("dp0", 32'(bus0.dp), 32'(x_dp));
      check("fd0", 32'(bus0.frame_done), 32'(x_fd));
      model_step(1, x_an, x_seg, x_dp, x_fd);
      check("an1", 32'(bus1.an), 32'(x_an));
      check("seg1", 32'(bus1.seg), 32'(x_seg));
      check("dp1", 32'(bus1.dp), 32'(x_dp));
      check("fd1", 32'(bus1.frame_done), 32'(x_fd));
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_display_scan.md
Name: clock_display_scan

Overview:
- Multiplexed six-digit 7-segment display driver for the alarm clock's BCD time outputs.
- Consumes H1/H0 (hours), M1/M0 (minutes), S1/S0 (seconds) and the Alarm flag from the clock core.
- Snapshots all digits once per frame so a displayed frame never mixes two times.
- Scans one digit at a time, decodes BCD to segments and blinks the whole display while Alarm is high.

Parameters:
- SCAN_DIV, 4, clk cycles each digit stays enabled (≥2).
- BLINK_FRAMES, 32, scan frames per blink half-period.
- ACTIVE_LOW_OUT, 1, 1 = an/seg/dp driven active-low (common-anode); 0 = active-high.
- LZ_BLANK, 1, 1 = blank the hour-tens digit when its value is 0.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- H_in1  in  2  hour tens, BCD.
- H_in0  in  4  hour units, BCD.
- M_in1  in  4  minute tens, BCD.
- M_in0  in  4  minute units, BCD.
- S_in1  in  4  second tens, BCD.
- S_in0  in  4  second units, BCD.
- Alarm  in  1  alarm active; enables blinking.
- an  out  6  digit enables, one-hot when lit; an[0]=S0 ... an[5]=H1.
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dp  out  1  decimal point (used as the separator).
- frame_done  out  1  one-cycle pulse on each 5→0 digit-index wrap.

Behaviour:
- Reset (reset==0 at a clk edge):
  - pre_cnt=0, idx=0, blink_cnt=0, blink_off=0, frame_done=0.
  - an/seg/dp at "off" level: all 1 if ACTIVE_LOW_OUT, else all 0.
  - Snapshot registers load the inputs every reset cycle, so the first frame after reset shows the current time.
- Prescaler: pre_cnt counts 0..SCAN_DIV-1 and wraps. At terminal count (tc), idx advances 0,1,...,5 and wraps to 0.
- Frame wrap (tc && idx==5):
  - Snapshot loads all six digits plus Alarm.
  - frame_done=1 for exactly one cycle (the cycle after that edge).
  - blink_cnt increments; when blink_cnt reaches BLINK_FRAMES-1 it wraps to 0 and blink_off toggles.
- Digit map (idx → digit): 0→S0, 1→S1, 2→M0, 3→M1, 4→H0, 5→H1.
- Output stage is registered. an/seg/dp reflect (idx, snapshot, blink_off) from the previous cycle, so there is one clk of latency. Each digit is lit for exactly SCAN_DIV cycles.
- Decode: standard 0-9 patterns (active-high: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F). Digit values 10-15 display dash (g only, 40h). H1 is zero-extended to 4 bits before decode.
- Leading-zero blank: if LZ_BLANK and snapshot H1==0, then during idx 5 an, seg and dp are all off.
- Separator: dp is lit on idx 2 and idx 4 when snapshot S0[0]==0; otherwise off.
- Blink:
  - If snapshot Alarm==1 and blink_off==1, an, seg and dp are all off for the whole frame; the scan keeps running.
  - If snapshot Alarm==0, blink_off is forced to 0 and blink_cnt to 0 at the next frame wrap, so the display returns visible immediately.
- Polarity: ACTIVE_LOW_OUT inverts an, seg and dp at the output register only.
- Reset mid-frame: takes effect on the next edge; idx returns to 0 and any pending frame_done is dropped.
- Input changes mid-frame have no effect until the next frame wrap.

Decomposition:
- Shared package clock_pkg holds:
  - digit-index constants IDX_S0..IDX_H1;
  - 7-bit segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF;
  - a bcd_to_seg function.
- One sub-module is natural: seg7_decode (4-bit BCD in, 7-bit active-high seg out, dash for >9). It is combinational, reusable by the alarm-set display, and instantiated once on the muxed digit.

Test Plan:
- Default polarity, SCAN_DIV=4. Time 12:34:56, Alarm=0, release reset → an walks 111110, 111101, ... 011111, 4 clks each. seg pattern for S0 = ~7D&7F = 02h. frame_done pulses every 24 clks.
- Snapshot coherence: change inputs from 12:34:56 to 12:34:57 at idx=2 → rest of frame shows 56; next frame S0 shows 7 (seg ~07=78h).
- Leading zero: H1=0, H0=7, LZ_BLANK=1 → during idx 5, an=111111 and seg=7Fh. With LZ_BLANK=0, seg=40h (~3F).
- Invalid BCD: M0=12 → idx 2 shows seg ~40h=3Fh (dash); no other digit is affected.
- Blink: BLINK_FRAMES=2, Alarm=1 → 2 frames lit, 2 frames all-off, repeating. Drop Alarm → display is lit from the next frame onward.
- Reset mid-frame at idx=3 → next cycle outputs off and frame_done=0; scan restarts at idx 0 with the newly sampled digits.
